// File: rtl/matrix_mult_pkg.sv
// Shared types and fixed-point helpers for the matrix multiplier.
// Contents: FSM state enum, default element format, and width/slice
// helper functions used by matrix_mult and matrix_mult_mac.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } mm_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_FRAC_WIDTH = 8;

    // Index width for a dimension; a dimension of 1 still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full-precision accumulator: product width plus growth for k terms.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
        return 2 * dw + $clog2(k);
    endfunction

    // Result slice bounds that map a Q*.2F product sum back to Q*.F.
    function automatic int unsigned res_lsb(input int unsigned fw);
        return fw;
    endfunction

    function automatic int unsigned res_msb(input int unsigned dw, input int unsigned fw);
        return dw + fw - 1;
    endfunction

endpackage

// File: rtl/matrix_mult_mac.sv
// Signed multiply-accumulate for one C element.
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears the accumulator)
//   en_i        - perform one MAC this cycle
//   clr_i       - with en_i, start a new sum (product replaces accumulator)
//   a_i, b_i    - signed fixed-point operands
//   res_c_o     - combinational truncated/wrapped result of the sum that
//                 the accumulator takes at the next edge
module matrix_mult_mac
    import matrix_mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int unsigned K          = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] res_c_o
);

    localparam int unsigned ACC_W   = acc_width(DATA_WIDTH, K);
    localparam int unsigned RES_LSB = res_lsb(FRAC_WIDTH);
    localparam int unsigned RES_MSB = res_msb(DATA_WIDTH, FRAC_WIDTH);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0]        acc_d;

    // Sign-extended product added to the running (or freshly cleared) sum.
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (en_i) begin
            acc_d = (clr_i ? ACC_W'(0) : acc_q) + ACC_W'(prod);
        end
    end

    // Dropping the low bits floors toward minus infinity; high bits wrap.
    assign res_c_o = acc_d[RES_MSB:RES_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mult.sv
// Fixed-point matrix multiplier C = A * B (A is MxK, B is KxN).
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   start                        - begin a new multiply (IDLE/DONE only)
//   a_data/a_row/a_col/a_valid   - A element write port (LOAD only)
//   b_data/b_row/b_col/b_valid   - B element write port (LOAD only)
//   c_data/c_row/c_col/c_valid   - C element stream, row-major
//   done                         - all C elements emitted
module matrix_mult
    import matrix_mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int unsigned M          = 4,
    parameter int unsigned N          = 2,
    parameter int unsigned K          = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] a_data,
    input  logic [idx_width(M)-1:0]      a_row,
    input  logic [idx_width(K)-1:0]      a_col,
    input  logic                         a_valid,
    input  logic signed [DATA_WIDTH-1:0] b_data,
    input  logic [idx_width(K)-1:0]      b_row,
    input  logic [idx_width(N)-1:0]      b_col,
    input  logic                         b_valid,
    output logic signed [DATA_WIDTH-1:0] c_data,
    output logic [idx_width(M)-1:0]      c_row,
    output logic [idx_width(N)-1:0]      c_col,
    output logic                         c_valid,
    output logic                         done
);

    localparam int unsigned MW  = idx_width(M);
    localparam int unsigned NW  = idx_width(N);
    localparam int unsigned KW  = idx_width(K);
    localparam int unsigned KCW = $clog2(K + 1);
    localparam int unsigned AFW = idx_width(M * K);
    localparam int unsigned BFW = idx_width(K * N);

    mm_state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] a_mem [M][K];
    logic signed [DATA_WIDTH-1:0] b_mem [K][N];

    logic [M*K-1:0] a_flag_q, a_flag_d;
    logic [K*N-1:0] b_flag_q, b_flag_d;

    logic [MW-1:0]  i_q, i_d;
    logic [NW-1:0]  j_q, j_d;
    logic [KCW-1:0] k_q, k_d;

    logic signed [DATA_WIDTH-1:0] c_data_q, c_data_d;
    logic [MW-1:0]                c_row_q, c_row_d;
    logic [NW-1:0]                c_col_q, c_col_d;
    logic                         c_valid_q, c_valid_d;
    logic                         done_q, done_d;

    logic                         a_wr, b_wr, all_loaded;
    logic [AFW-1:0]               a_idx;
    logic [BFW-1:0]               b_idx;
    logic [KW-1:0]                k_idx;
    logic                         mac_en, mac_clr;
    logic signed [DATA_WIDTH-1:0] mac_res;

    // Writes only land in LOAD and only with in-range indices.
    assign a_wr = (state_q == ST_LOAD) && a_valid && (32'(a_row) < M) && (32'(a_col) < K);
    assign b_wr = (state_q == ST_LOAD) && b_valid && (32'(b_row) < K) && (32'(b_col) < N);
    assign a_idx = AFW'(32'(a_row) * K + 32'(a_col));
    assign b_idx = BFW'(32'(b_row) * N + 32'(b_col));
    assign all_loaded = (&a_flag_q) && (&b_flag_q);

    // k_q reaches K on the emit cycle; keep the operand index in range then.
    assign k_idx = (k_q < KCW'(K)) ? KW'(k_q) : '0;

    // Operand storage is not reset; loaded flags gate its use.
    always_ff @(posedge clk) begin
        if (a_wr) begin
            a_mem[a_row][a_col] <= a_data;
        end
        if (b_wr) begin
            b_mem[b_row][b_col] <= b_data;
        end
    end

    matrix_mult_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .K          (K)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mac_en),
        .clr_i   (mac_clr),
        .a_i     (a_mem[i_q][k_idx]),
        .b_i     (b_mem[k_idx][j_q]),
        .res_c_o (mac_res)
    );

    // Next-state and datapath control; each C element takes K MAC cycles
    // followed by one emit cycle.
    always_comb begin
        state_d   = state_q;
        a_flag_d  = a_flag_q;
        b_flag_d  = b_flag_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        c_data_d  = c_data_q;
        c_row_d   = c_row_q;
        c_col_d   = c_col_q;
        c_valid_d = 1'b0;
        done_d    = done_q;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    a_flag_d = '0;
                    b_flag_d = '0;
                    done_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (a_wr) a_flag_d[a_idx] = 1'b1;
                if (b_wr) b_flag_d[b_idx] = 1'b1;
                if (all_loaded) begin
                    state_d = ST_COMPUTE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ST_COMPUTE: begin
                if (k_q != KCW'(K)) begin
                    mac_en  = 1'b1;
                    mac_clr = (k_q == '0);
                    k_d     = k_q + KCW'(1);
                    if (k_q == KCW'(K - 1)) begin
                        c_valid_d = 1'b1;
                        c_data_d  = mac_res;
                        c_row_d   = i_q;
                        c_col_d   = j_q;
                    end
                end else begin
                    k_d = '0;
                    if (j_q == NW'(N - 1)) begin
                        j_d = '0;
                        if (i_q == MW'(M - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            i_d = i_q + MW'(1);
                        end
                    end else begin
                        j_d = j_q + NW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_flag_q  <= '0;
            b_flag_q  <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            c_data_q  <= '0;
            c_row_q   <= '0;
            c_col_q   <= '0;
            c_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_flag_q  <= a_flag_d;
            b_flag_q  <= b_flag_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            c_data_q  <= c_data_d;
            c_row_q   <= c_row_d;
            c_col_q   <= c_col_d;
            c_valid_q <= c_valid_d;
            done_q    <= done_d;
        end
    end

    assign c_data  = c_data_q;
    assign c_row   = c_row_q;
    assign c_col   = c_col_q;
    assign c_valid = c_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_matrix_mult.sv
// Directed testbench for matrix_mult (Q8.8, M=4, N=2, K=3).
module tb_matrix_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_data;
    logic [1:0]  a_row;
    logic [1:0]  a_col;
    logic        a_valid;
    logic [15:0] b_data;
    logic [1:0]  b_row;
    logic [0:0]  b_col;
    logic        b_valid;
    logic [15:0] c_data;
    logic [1:0]  c_row;
    logic [0:0]  c_col;
    logic        c_valid;
    logic        done;

    matrix_mult #(
        .DATA_WIDTH (16),
        .FRAC_WIDTH (8),
        .M          (4),
        .N          (2),
        .K          (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_data  (a_data),
        .a_row   (a_row),
        .a_col   (a_col),
        .a_valid (a_valid),
        .b_data  (b_data),
        .b_row   (b_row),
        .b_col   (b_col),
        .b_valid (b_valid),
        .c_data  (c_data),
        .c_row   (c_row),
        .c_col   (c_col),
        .c_valid (c_valid),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] ma [4][3];
    logic [15:0] mb [3][2];
    logic [15:0] mc [4][2];
    int          a_ord [11];
    int          b_ord [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_clr"}, {31'h0, done}, 32'h0);
    endtask

    // One A write per cycle; B written alongside during the first six cycles.
    task automatic load_all();
        for (int s = 0; s < 12; s++) begin
            a_row   = 2'(s / 3);
            a_col   = 2'(s % 3);
            a_data  = ma[s / 3][s % 3];
            a_valid = 1'b1;
            if (s < 6) begin
                b_row   = 2'(s / 2);
                b_col   = 1'(s % 2);
                b_data  = mb[s / 2][s % 2];
                b_valid = 1'b1;
            end else begin
                b_valid = 1'b0;
            end
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Collect 8 results, check order/values/spacing, then done behaviour.
    task automatic collect(input string tag, output int first);
        int got;
        int cyc;
        int last;
        got   = 0;
        cyc   = 0;
        last  = 0;
        first = 0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (c_valid === 1'b1) begin
                check($sformatf("%s_nodone%0d", tag, got), {31'h0, done}, 32'h0);
                check($sformatf("%s_row%0d", tag, got), {30'h0, c_row}, 32'(got / 2));
                check($sformatf("%s_col%0d", tag, got), {31'h0, c_col}, 32'(got % 2));
                check($sformatf("%s_data%0d", tag, got), {16'h0, c_data}, {16'h0, mc[got / 2][got % 2]});
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
        end
        check({tag, "_count"}, 32'(got), 32'd8);
        check({tag, "_spacing"}, 32'(last - first), 32'd28);
        @(negedge clk);
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_valid_low"}, {31'h0, c_valid}, 32'h0);
        check({tag, "_hold"}, {16'h0, c_data}, {16'h0, mc[3][1]});
    endtask

    task automatic set_int();
        ma = '{'{16'h0100, 16'h0200, 16'h0300}, '{16'h0400, 16'h0500, 16'h0600},
               '{16'h0700, 16'h0800, 16'h0900}, '{16'h0100, 16'h0000, 16'h0200}};
        mb = '{'{16'h0100, 16'h0000}, '{16'h0000, 16'h0100}, '{16'h0100, 16'h0100}};
        mc = '{'{16'h0400, 16'h0500}, '{16'h0A00, 16'h0B00},
               '{16'h1000, 16'h1100}, '{16'h0300, 16'h0200}};
    endtask

    // C[1][0] = 2*2 + 0.5*1 + 1*0.5 = 5.0
    task automatic set_frac();
        ma = '{'{16'h0080, 16'h0180, 16'h0040}, '{16'h0200, 16'h0080, 16'h0100},
               '{16'h0040, 16'h00C0, 16'h0140}, '{16'h0100, 16'h0100, 16'h0100}};
        mb = '{'{16'h0200, 16'h0080}, '{16'h0100, 16'h0200}, '{16'h0080, 16'h0100}};
        mc = '{'{16'h02A0, 16'h0380}, '{16'h0500, 16'h0300},
               '{16'h01E0, 16'h02E0}, '{16'h0380, 16'h0380}};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int early;
        int seen;
        int quiet;

        rst_n = 1'b0; start = 1'b0;
        a_data = '0; a_row = '0; a_col = '0; a_valid = 1'b0;
        b_data = '0; b_row = '0; b_col = '0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, c_valid}, 32'h0);
        check("rst_done",  {31'h0, done}, 32'h0);
        check("rst_data",  {16'h0, c_data}, 32'h0);
        check("rst_row",   {30'h0, c_row}, 32'h0);
        check("rst_col",   {31'h0, c_col}, 32'h0);
        rst_n = 1'b1;
        step();

        // Integer matrices
        set_int();
        do_start("int");
        load_all();
        collect("int", first);
        check("int_latency", 32'(first), 32'd5);
        repeat (3) @(negedge clk);
        check("int_done_stays", {31'h0, done}, 32'h1);

        // Fractions, restarted from DONE
        set_frac();
        do_start("frac");
        load_all();
        collect("frac", first);

        // Identity rows
        ma = '{'{16'h0100, 16'h0000, 16'h0000}, '{16'h0000, 16'h0100, 16'h0000},
               '{16'h0000, 16'h0000, 16'h0100}, '{16'h0000, 16'h0000, 16'h0000}};
        mb = '{'{16'h0500, 16'h0300}, '{16'h0200, 16'h0700}, '{16'h0100, 16'h0400}};
        mc = '{'{16'h0500, 16'h0300}, '{16'h0200, 16'h0700},
               '{16'h0100, 16'h0400}, '{16'h0000, 16'h0000}};
        do_start("ident");
        load_all();
        collect("ident", first);

        // Shuffled load: A[1][1] first written wrong then fixed, A[2][0] last,
        // out-of-range writes and a stray start in between
        set_int();
        a_ord = '{4, 11, 0, 9, 2, 7, 5, 1, 10, 3, 8};
        b_ord = '{5, 2, 0, 3, 1, 4};
        do_start("shuf");
        for (int s = 0; s < 12; s++) begin
            int ai;
            ai      = (s < 11) ? a_ord[s] : 4;
            a_row   = 2'(ai / 3);
            a_col   = 2'(ai % 3);
            a_data  = (s == 0) ? 16'h6300 : ma[ai / 3][ai % 3];
            a_valid = 1'b1;
            if (s < 6) begin
                b_row   = 2'(b_ord[s] / 2);
                b_col   = 1'(b_ord[s] % 2);
                b_data  = mb[b_ord[s] / 2][b_ord[s] % 2];
                b_valid = 1'b1;
            end else begin
                b_valid = 1'b0;
            end
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        early = 0;
        for (int g = 0; g < 8; g++) begin
            if (g == 0) begin
                a_row = 2'd1; a_col = 2'd3; a_data = 16'h7777; a_valid = 1'b1;
                b_row = 2'd3; b_col = 1'd0; b_data = 16'h7777; b_valid = 1'b1;
            end
            if (g == 2) start = 1'b1;
            step();
            a_valid = 1'b0;
            b_valid = 1'b0;
            start   = 1'b0;
            @(negedge clk);
            if (c_valid === 1'b1 || done === 1'b1) early++;
        end
        check("shuf_early", 32'(early), 32'd0);
        a_row = 2'd2; a_col = 2'd0; a_data = ma[2][0]; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        collect("shuf", first);
        check("shuf_latency", 32'(first), 32'd5);

        // Negative values, wrap on overflow, floor truncation
        ma = '{'{16'hFE80, 16'hFE80, 16'hFE80}, '{16'hFFFF, 16'h0000, 16'h0000},
               '{16'h0000, 16'h0001, 16'h0000}, '{16'h0000, 16'hFFFF, 16'h0000}};
        mb = '{'{16'h7F00, 16'h0100}, '{16'h7F00, 16'h0080}, '{16'h7F00, 16'h0000}};
        mc = '{'{16'hC480, 16'hFDC0}, '{16'hFF81, 16'hFFFF},
               '{16'h007F, 16'h0000}, '{16'hFF81, 16'hFFFF}};
        do_start("neg");
        load_all();
        collect("neg", first);

        // Reset in the middle of COMPUTE
        set_int();
        do_start("rstc");
        load_all();
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            @(negedge clk);
            if (c_valid === 1'b1) seen = 1;
        end
        check("rstc_first_valid", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstc_valid", {31'h0, c_valid}, 32'h0);
        check("rstc_done",  {31'h0, done}, 32'h0);
        check("rstc_data",  {16'h0, c_data}, 32'h0);
        check("rstc_row",   {30'h0, c_row}, 32'h0);
        check("rstc_col",   {31'h0, c_col}, 32'h0);
        step();
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c_valid === 1'b1 || done === 1'b1) quiet++;
        end
        check("rstc_quiet", 32'(quiet), 32'd0);
        set_frac();
        do_start("after_rst");
        load_all();
        collect("after_rst", first);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
